// File: rtl/sensor_emu_pkg.sv
// sensor_emu_pkg
//   Shared types and constants for the sensor emulator scheduler.
//   - state_t      : scheduler FSM states
//   - FSEL_*       : FIFO-select encoding used on i_ACTIVE_FIFO / o_START
//   - other_fifo() : returns the ping-pong partner of a FIFO select value
package sensor_emu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SETTLE,
    LOAD,
    START,
    WAIT_ACT,
    DRAIN
  } state_t;

  localparam logic [1:0] FSEL_NONE = 2'd0;
  localparam logic [1:0] FSEL_F0   = 2'd1;
  localparam logic [1:0] FSEL_F1   = 2'd2;

  localparam int DEFAULT_FIFO_DEPTH = 8192;

  function automatic logic [1:0] other_fifo(input logic [1:0] fsel);
    return (fsel == FSEL_F0) ? FSEL_F1 : FSEL_F0;
  endfunction

endpackage

// File: rtl/sensor_emu_sched.sv
// sensor_emu_sched
//   Ping-pong scheduler for the sensor emulator's two pattern FIFOs. Each
//   TLAST-delimited set arriving on AXIS_IN is loaded into the FIFO that is
//   not currently streaming (after clearing it), then output is switched over.
// Ports:
//   clk, resetn            : clock, synchronous active-low reset
//   AXIS_IN_*              : pattern word stream (TREADY is combinational)
//   i_soft_stop/hard_stop  : single-cycle stop requests
//   i_FIFO_STAT_f*_ready   : emulator FIFO ready after clear
//   i_ACTIVE_FIFO          : emulator's streaming FIFO (0 none, 1 F0, 2 F1)
//   o_FIFO_CTL_*, o_LOAD_*, o_UPPER32, o_START*, o_HARD_STOP_wstrobe :
//                            registered emulator register writes
//   o_busy                 : FSM not in IDLE
//   o_overflow             : sticky, a word arrived with the set already full
//   o_sets_started         : number of completed FIFO switches (wraps)
module sensor_emu_sched
  import sensor_emu_pkg::*;
#(
  parameter int PATTERN_WIDTH = 32,
  parameter int FIFO_DEPTH    = DEFAULT_FIFO_DEPTH,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [PATTERN_WIDTH-1:0] AXIS_IN_TDATA,
  input  logic                     AXIS_IN_TVALID,
  input  logic                     AXIS_IN_TLAST,
  output logic                     AXIS_IN_TREADY,
  input  logic                     i_soft_stop,
  input  logic                     i_hard_stop,
  input  logic                     i_FIFO_STAT_f0_ready,
  input  logic                     i_FIFO_STAT_f1_ready,
  input  logic [1:0]               i_ACTIVE_FIFO,
  output logic                     o_FIFO_CTL_f0_reset,
  output logic                     o_FIFO_CTL_f1_reset,
  output logic                     o_FIFO_CTL_wstrobe,
  output logic [31:0]              o_UPPER32,
  output logic [31:0]              o_LOAD_F0,
  output logic                     o_LOAD_F0_wstrobe,
  output logic [31:0]              o_LOAD_F1,
  output logic                     o_LOAD_F1_wstrobe,
  output logic [1:0]               o_START,
  output logic                     o_START_wstrobe,
  output logic                     o_HARD_STOP_wstrobe,
  output logic                     o_busy,
  output logic                     o_overflow,
  output logic [31:0]              o_sets_started
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1) + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] SETTLE_C = SW'(SETTLE_CYCLES);

  state_t      state_q, state_d;
  logic [1:0]  tgt_q, tgt_d;
  logic [1:0]  toggle_q, toggle_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] settle_q, settle_d;
  logic        soft_pend_q, soft_pend_d;
  logic        ctl_f0_q, ctl_f0_d, ctl_f1_q, ctl_f1_d, ctl_ws_q, ctl_ws_d;
  logic [31:0] upper_q, upper_d;
  logic [31:0] load_f0_q, load_f0_d, load_f1_q, load_f1_d;
  logic        load_f0_ws_q, load_f0_ws_d, load_f1_ws_q, load_f1_ws_d;
  logic [1:0]  start_q, start_d;
  logic        start_ws_q, start_ws_d;
  logic        hard_ws_q, hard_ws_d;
  logic        overflow_q, overflow_d;
  logic [31:0] sets_q, sets_d;

  logic        tgt_ready;
  logic        tready;
  logic        hs;
  logic [31:0] data_lo;
  logic [31:0] data_hi;

  // Low word is zero-extended for narrow patterns, truncated for 64-bit.
  assign data_lo = 32'(AXIS_IN_TDATA);

  generate
    if (PATTERN_WIDTH == 64) begin : g_upper
      assign data_hi = AXIS_IN_TDATA[PATTERN_WIDTH-1:32];
    end else begin : g_no_upper
      assign data_hi = 32'd0;
    end
  endgenerate

  assign tgt_ready = (tgt_q == FSEL_F0) ? i_FIFO_STAT_f0_ready : i_FIFO_STAT_f1_ready;

  // Masking TREADY with the hard stop guarantees a word offered in the same
  // cycle as a hard stop is never loaded.
  always_comb begin
    tready = 1'b0;
    case (state_q)
      LOAD:    tready = tgt_ready & ~i_hard_stop;
      DRAIN:   tready = 1'b1;
      default: tready = 1'b0;
    endcase
  end

  assign hs = AXIS_IN_TVALID & tready;

  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    toggle_d     = toggle_q;
    cnt_d        = cnt_q;
    settle_d     = settle_q;
    soft_pend_d  = soft_pend_q;
    ctl_f0_d     = 1'b0;
    ctl_f1_d     = 1'b0;
    ctl_ws_d     = 1'b0;
    upper_d      = upper_q;
    load_f0_d    = load_f0_q;
    load_f1_d    = load_f1_q;
    load_f0_ws_d = 1'b0;
    load_f1_ws_d = 1'b0;
    start_d      = start_q;
    start_ws_d   = 1'b0;
    hard_ws_d    = i_hard_stop;
    overflow_d   = overflow_q;
    sets_d       = sets_q;

    case (state_q)
      IDLE: begin
        // A soft stop seen here, or one deferred from a busy state, is issued
        // as a START write of "no FIFO".
        if (soft_pend_q || i_soft_stop) begin
          start_d     = FSEL_NONE;
          start_ws_d  = 1'b1;
          soft_pend_d = 1'b0;
        end
        if (AXIS_IN_TVALID) begin
          state_d = CLEAR;
          if (i_ACTIVE_FIFO == FSEL_F0)      tgt_d = FSEL_F1;
          else if (i_ACTIVE_FIFO == FSEL_F1) tgt_d = FSEL_F0;
          else                               tgt_d = toggle_q;
        end
      end
      CLEAR: begin
        ctl_ws_d = 1'b1;
        ctl_f0_d = (tgt_q == FSEL_F0);
        ctl_f1_d = (tgt_q == FSEL_F1);
        cnt_d    = '0;
        settle_d = '0;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q < SETTLE_C) settle_d = settle_q + 1'b1;
        else if (tgt_ready)      state_d  = LOAD;
      end
      LOAD: begin
        if (hs) begin
          if (cnt_q < DEPTH_C) begin
            cnt_d   = cnt_q + 1'b1;
            upper_d = data_hi;
            if (tgt_q == FSEL_F0) begin
              load_f0_d    = data_lo;
              load_f0_ws_d = 1'b1;
            end else begin
              load_f1_d    = data_lo;
              load_f1_ws_d = 1'b1;
            end
          end else begin
            overflow_d = 1'b1;
          end
          if (AXIS_IN_TLAST) state_d = START;
        end
      end
      START: begin
        start_d    = tgt_q;
        start_ws_d = 1'b1;
        state_d    = WAIT_ACT;
      end
      WAIT_ACT: begin
        if (i_ACTIVE_FIFO == tgt_q) begin
          sets_d   = sets_q + 32'd1;
          toggle_d = other_fifo(tgt_q);
          state_d  = IDLE;
        end
      end
      DRAIN: begin
        if (hs && AXIS_IN_TLAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (i_soft_stop && (state_q != IDLE)) soft_pend_d = 1'b1;

    // Hard stop overrides everything: no START write this cycle, any pending
    // soft stop is dropped, and a partially loaded set is drained.
    if (i_hard_stop) begin
      soft_pend_d = 1'b0;
      start_d     = start_q;
      start_ws_d  = 1'b0;
      state_d     = (state_q == LOAD) ? DRAIN : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      tgt_q        <= FSEL_F0;
      toggle_q     <= FSEL_F0;
      cnt_q        <= '0;
      settle_q     <= '0;
      soft_pend_q  <= 1'b0;
      ctl_f0_q     <= 1'b0;
      ctl_f1_q     <= 1'b0;
      ctl_ws_q     <= 1'b0;
      upper_q      <= '0;
      load_f0_q    <= '0;
      load_f1_q    <= '0;
      load_f0_ws_q <= 1'b0;
      load_f1_ws_q <= 1'b0;
      start_q      <= FSEL_NONE;
      start_ws_q   <= 1'b0;
      hard_ws_q    <= 1'b0;
      overflow_q   <= 1'b0;
      sets_q       <= '0;
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      toggle_q     <= toggle_d;
      cnt_q        <= cnt_d;
      settle_q     <= settle_d;
      soft_pend_q  <= soft_pend_d;
      ctl_f0_q     <= ctl_f0_d;
      ctl_f1_q     <= ctl_f1_d;
      ctl_ws_q     <= ctl_ws_d;
      upper_q      <= upper_d;
      load_f0_q    <= load_f0_d;
      load_f1_q    <= load_f1_d;
      load_f0_ws_q <= load_f0_ws_d;
      load_f1_ws_q <= load_f1_ws_d;
      start_q      <= start_d;
      start_ws_q   <= start_ws_d;
      hard_ws_q    <= hard_ws_d;
      overflow_q   <= overflow_d;
      sets_q       <= sets_d;
    end
  end

  assign AXIS_IN_TREADY      = tready;
  assign o_FIFO_CTL_f0_reset = ctl_f0_q;
  assign o_FIFO_CTL_f1_reset = ctl_f1_q;
  assign o_FIFO_CTL_wstrobe  = ctl_ws_q;
  assign o_UPPER32           = upper_q;
  assign o_LOAD_F0           = load_f0_q;
  assign o_LOAD_F0_wstrobe   = load_f0_ws_q;
  assign o_LOAD_F1           = load_f1_q;
  assign o_LOAD_F1_wstrobe   = load_f1_ws_q;
  assign o_START             = start_q;
  assign o_START_wstrobe     = start_ws_q;
  assign o_HARD_STOP_wstrobe = hard_ws_q;
  assign o_busy              = (state_q != IDLE);
  assign o_overflow          = overflow_q;
  assign o_sets_started      = sets_q;

endmodule
